ht_5_encoder: RTL and testbench
===============================

HT_5_ENCODER -- requirements
Module: ht_5_encoder

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 s_valid  input  1  an (x,y) pair is offered on x_val/y_val.
REQ-004 s_ready  output  1  encoder accepts the pair this cycle; transfer occurs when s_valid && s_ready.
REQ-005 x_val  input  4  unsigned magnitude of x; legal range 0..3.
REQ-006 y_val  input  4  unsigned magnitude of y; legal range 0..3.
REQ-007 x_sign, y_sign  input  1 each  sign bits (1 = negative); sampled with the pair.
REQ-008 axiov  output  1  serial bit valid.
REQ-009 axiod  output  1  serial bit, MSB of codeword first.
REQ-010 axiol  output  1  marks the final bit of the current pair's symbol.
REQ-011 axior  input  1  downstream ready; a bit transfers when axiov && axior.
REQ-012 err  output  1  one-cycle pulse: the accepted pair had x_val > 3 or y_val > 3.

Function
REQ-013 Code table (x,y -> bits): (0,0) 1; (0,1) 010; (1,0) 011; (1,1) 001; (0,2) 000110; (1,2) 000100; (2,0) 000111; (2,1) 000101; (3,1) 000001; (0,3) 0000101; (1,3) 0000100; (2,2) 0000111; (3,0) 0000110; (3,2) 0000001; (2,3) 00000001; (3,3) 00000000.
REQ-014 States: IDLE and SHIFT. IDLE -> SHIFT on an accepted legal pair. SHIFT -> IDLE on the last-bit transfer unless a new legal pair is accepted in the same cycle.
REQ-015 Latency: for a pair accepted in cycle T, the first bit shall appear on axiod with axiov=1 in cycle T+1.
REQ-016 In SHIFT, axiov=1 and axiod holds the current bit until axior=1; the bit index advances only on transfer.
REQ-017 s_ready = (state==IDLE) || (axiov && axiol && axior); back-to-back symbols shall occur with no bubble cycle.
REQ-018 An illegal pair (x or y > 3) shall be accepted, shall not be encoded, and shall raise err in cycle T+1; the state remains or returns to IDLE.
REQ-019 The bit counter is 4 bits; the symbol length is 1..10 bits; axiol=1 exactly when the counter equals length-1.
REQ-020 s_valid=0 in IDLE: axiov=0, no state change.

Reset
REQ-021 During rst: state=IDLE; axiov=0; axiod=0; axiol=0; err=0; s_ready=0. s_ready=1 in the first cycle after rst deasserts.
REQ-022 rst asserted mid-symbol shall abort the symbol; no remaining bits are emitted after reset.

Configuration
REQ-023 HT5_SIGN_EN defined: after the codeword, append x_sign if x_val!=0, then y_sign if y_val!=0; axiol moves to the last appended bit.
REQ-024 HT5_SIGN_EN undefined: x_sign and y_sign are ignored; the symbol is the codeword only (max 8 bits).

Structure
REQ-025 Package ht5_pkg holds the state enum, MAX_CODE_LEN=8, MAX_SYM_LEN=10, and the 16-entry code/length table as constants.
REQ-026 Sub-module ht5_code_lut shall be purely combinational: (x,y) -> {code[7:0] left-aligned, len[3:0]}. The encoder registers its output into a shift register on accept.

Verification
REQ-027 Send (0,0) with axior=1 -> T+1: axiod=1, axiol=1; s_ready=1 in the same cycle.
REQ-028 Send (2,3) then (1,1) back-to-back, axior=1 -> bits 00000001 then 001, with axiol on bits 8 and 11 and no gap cycle.
REQ-029 Send (3,0) with axior toggling 1,0,1,0... -> 0000110 emitted; each bit is held across stalled cycles; total 13 cycles.
REQ-030 Send x_val=5, y_val=0 -> err=1 for one cycle at T+1, axiov stays 0, the next pair is encoded normally.
REQ-031 Pulse rst on the 3rd bit of (0,3) -> axiov=0 after rst and s_ready=1 afterward; a following (1,0) emits 011.
REQ-032 With HT5_SIGN_EN, send (2,0) with x_sign=1 -> bits 0001111 with axiol on bit 7; send (0,0) -> a single bit 1, no sign bits.

Source files
------------

// File: rtl/ht5_pkg.sv
// rtl/ht5_pkg.sv - shared state type, symbol limits and the 16-entry code/length table
package ht5_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int MAX_CODE_LEN = 8;
    localparam int MAX_SYM_LEN  = 10;

    // Indexed by {x[1:0], y[1:0]}; codewords are left-aligned in 8 bits.
    localparam logic [7:0] CODE_TBL [16] = '{
        8'b1000_0000,  // (0,0) 1
        8'b0100_0000,  // (0,1) 010
        8'b0001_1000,  // (0,2) 000110
        8'b0000_1010,  // (0,3) 0000101
        8'b0110_0000,  // (1,0) 011
        8'b0010_0000,  // (1,1) 001
        8'b0001_0000,  // (1,2) 000100
        8'b0000_1000,  // (1,3) 0000100
        8'b0001_1100,  // (2,0) 000111
        8'b0001_0100,  // (2,1) 000101
        8'b0000_1110,  // (2,2) 0000111
        8'b0000_0001,  // (2,3) 00000001
        8'b0000_1100,  // (3,0) 0000110
        8'b0000_0100,  // (3,1) 000001
        8'b0000_0010,  // (3,2) 0000001
        8'b0000_0000   // (3,3) 00000000
    };

    localparam logic [3:0] LEN_TBL [16] = '{
        4'd1, 4'd3, 4'd6, 4'd7,
        4'd3, 4'd3, 4'd6, 4'd7,
        4'd6, 4'd6, 4'd7, 4'd8,
        4'd7, 4'd6, 4'd7, 4'd8
    };

endpackage

// File: rtl/ht5_code_lut.sv
// rtl/ht5_code_lut.sv - combinational (x,y) to left-aligned codeword and length lookup
// Ports: x, y (2-bit magnitudes) in; code (8-bit, MSB first) and len (1..8) out.
import ht5_pkg::*;

module ht5_code_lut (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [7:0] code,
    output logic [3:0] len
);

    assign code = CODE_TBL[{x, y}];
    assign len  = LEN_TBL[{x, y}];

endmodule

// File: rtl/ht_5_encoder.sv
// rtl/ht_5_encoder.sv - serial Huffman encoder for (x,y) magnitude pairs
// Ports: clk, rst (sync, active-high); s_valid/s_ready handshake with x_val, y_val,
// x_sign, y_sign; serial output axiov/axiod/axiol with downstream axior; err pulse
// for an accepted out-of-range pair. Optional macro HT5_SIGN_EN appends sign bits.
import ht5_pkg::*;

module ht_5_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [3:0] x_val,
    input  logic [3:0] y_val,
    input  logic       x_sign,
    input  logic       y_sign,
    output logic       axiov,
    output logic       axiod,
    output logic       axiol,
    input  logic       axior,
    output logic       err
);

    state_t                   state, state_nxt;
    logic [MAX_SYM_LEN-1:0]   sh;
    logic [3:0]               len;
    logic [3:0]               cnt;
    logic                     err_q;

    logic [7:0]               lut_code;
    logic [3:0]               lut_len;
    logic [MAX_SYM_LEN-1:0]   sym_new;
    logic [3:0]               len_new;

    logic legal, accept, xfer, last, load;

    ht5_code_lut u_lut (
        .x    (x_val[1:0]),
        .y    (y_val[1:0]),
        .code (lut_code),
        .len  (lut_len)
    );

    assign legal   = (x_val <= 4'd3) && (y_val <= 4'd3);
    assign last    = (cnt == len - 4'd1);

    // Outputs are gated by rst so nothing leaks out while the register state
    // is being cleared.
    assign axiov   = !rst && (state == SHIFT);
    assign axiod   = axiov && sh[MAX_SYM_LEN-1];
    assign axiol   = axiov && last;
    assign err     = !rst && err_q;
    assign xfer    = axiov && axior;
    assign s_ready = !rst && ((state == IDLE) || (axiol && axior));
    assign accept  = s_valid && s_ready;
    assign load    = accept && legal;

    // Build the symbol left-aligned in the shift register.
    always_comb begin
        sym_new = {lut_code, 2'b00};
        len_new = lut_len;
`ifdef HT5_SIGN_EN
        if (x_val[1:0] != 2'd0) begin
            sym_new[4'd9 - len_new] = x_sign;
            len_new = len_new + 4'd1;
        end
        if (y_val[1:0] != 2'd0) begin
            sym_new[4'd9 - len_new] = y_sign;
            len_new = len_new + 4'd1;
        end
`endif
    end

`ifndef HT5_SIGN_EN
    logic sign_unused;
    assign sign_unused = x_sign ^ y_sign;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (xfer && last) state_nxt = load ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            len   <= 4'd0;
            cnt   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= accept && !legal;
            // A new load takes priority: it only coincides with the final-bit transfer.
            if (load) begin
                sh  <= sym_new;
                len <= len_new;
                cnt <= 4'd0;
            end else if (xfer) begin
                sh  <= {sh[MAX_SYM_LEN-2:0], 1'b0};
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ht_5_encoder.sv
// tb/tb_ht_5_encoder.sv - self-checking bench for ht_5_encoder with a bit-queue reference model
module tb_ht_5_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] x_val = 4'd0;
    logic [3:0] y_val = 4'd0;
    logic       x_sign = 1'b0;
    logic       y_sign = 1'b0;
    logic       axiov, axiod, axiol;
    logic       axior = 1'b0;
    logic       err;

    ht_5_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .x_val   (x_val),
        .y_val   (y_val),
        .x_sign  (x_sign),
        .y_sign  (y_sign),
        .axiov   (axiov),
        .axiod   (axiod),
        .axiol   (axiol),
        .axior   (axior),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending output bits and their last-bit flags.
    bit q_bit[$];
    bit q_last[$];
    bit exp_err = 0;
    bit acc = 0;
    int mode = 0;     // 0: axior=1, 1: toggle, 2: random
    bit tog = 1;
    int vcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic string code_of(input int x, input int y);
        case (x * 4 + y)
            0:  return "1";
            1:  return "010";
            2:  return "000110";
            3:  return "0000101";
            4:  return "011";
            5:  return "001";
            6:  return "000100";
            7:  return "0000100";
            8:  return "000111";
            9:  return "000101";
            10: return "0000111";
            11: return "00000001";
            12: return "0000110";
            13: return "000001";
            14: return "0000001";
            default: return "00000000";
        endcase
    endfunction

    task automatic push_symbol(input int x, input int y, input bit xs, input bit ys);
        string s;
        bit bits[$];
        s = code_of(x, y);
        for (int i = 0; i < s.len(); i++) bits.push_back(s[i] == "1");
`ifdef HT5_SIGN_EN
        if (x != 0) bits.push_back(xs);
        if (y != 0) bits.push_back(ys);
`endif
        for (int i = 0; i < bits.size(); i++) begin
            q_bit.push_back(bits[i]);
            q_last.push_back(i == bits.size() - 1);
        end
    endtask

    task automatic get_r(output bit r);
        case (mode)
            0: r = 1'b1;
            1: begin r = tog; tog = !tog; end
            default: r = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance model.
    task automatic step(input bit r, input bit sv, input logic [3:0] x, input logic [3:0] y,
                        input bit xs, input bit ys, input bit rs);
        bit exp_v, exp_rdy;
        @(negedge clk);
        rst = rs; s_valid = sv; x_val = x; y_val = y;
        x_sign = xs; y_sign = ys; axior = r;
        #1;
        acc = 0;
        if (rs) begin
            chk("rst_axiov", axiov, 0);
            chk("rst_axiod", axiod, 0);
            chk("rst_axiol", axiol, 0);
            chk("rst_err", err, 0);
            chk("rst_s_ready", s_ready, 0);
            q_bit.delete(); q_last.delete();
            exp_err = 0;
        end else begin
            exp_v   = (q_bit.size() != 0);
            exp_rdy = !exp_v || (q_last[0] && r);
            chk("axiov", axiov, exp_v);
            if (exp_v) begin
                chk("axiod", axiod, q_bit[0]);
                chk("axiol", axiol, q_last[0]);
                vcnt++;
            end else begin
                chk("axiol_idle", axiol, 0);
            end
            chk("s_ready", s_ready, exp_rdy);
            chk("err", err, exp_err);
            exp_err = 0;
            if (exp_v && r) begin
                void'(q_bit.pop_front());
                void'(q_last.pop_front());
            end
            if (sv && exp_rdy) begin
                acc = 1;
                if (x <= 3 && y <= 3) push_symbol(int'(x), int'(y), xs, ys);
                else exp_err = 1;
            end
        end
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y, input bit xs, input bit ys);
        int n = 0;
        bit r;
        acc = 0;
        while (!acc && n < 30) begin
            get_r(r);
            step(r, 1'b1, x, y, xs, ys, 1'b0);
            n++;
        end
        chk("send_timeout", acc, 1);
        tog = 1;
    endtask

    task automatic idle(input int cycles);
        bit r;
        for (int i = 0; i < cycles; i++) begin
            get_r(r);
            step(r, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        int n = 0;
        bit r;
        while (q_bit.size() != 0 && n < 60) begin
            get_r(r);
            step(r, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("drain_timeout", q_bit.size() == 0, 1);
    endtask

    initial begin
        // Reset, then first cycle after release must be ready.
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Single-bit symbol (0,0).
        mode = 0;
        send(4'd0, 4'd0, 1'b0, 1'b0);
        drain();
        idle(1);

        // Back-to-back (2,3) then (1,1), no bubble.
        send(4'd2, 4'd3, 1'b0, 1'b0);
        vcnt = 0;
        send(4'd1, 4'd1, 1'b0, 1'b0);
        drain();
        chk("b2b_valid_cycles", vcnt, 11);
        idle(1);

        // (3,0) with axior toggling.
        mode = 1;
        send(4'd3, 4'd0, 1'b0, 1'b0);
        vcnt = 0;
        drain();
        chk("toggle_cycles", vcnt, 13);
        mode = 0;
        idle(1);

        // Illegal pair then a normal one.
        send(4'd5, 4'd0, 1'b0, 1'b0);
        idle(2);
        send(4'd1, 4'd2, 1'b0, 1'b0);
        drain();
        idle(1);

        // Reset in the middle of (0,3), then (1,0).
        send(4'd0, 4'd3, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        send(4'd1, 4'd0, 1'b0, 1'b0);
        drain();
        idle(1);

`ifdef HT5_SIGN_EN
        send(4'd2, 4'd0, 1'b1, 1'b0);
        drain();
        send(4'd0, 4'd0, 1'b1, 1'b1);
        drain();
        idle(1);
`endif

        // Randomized traffic with random stalls, gaps and occasional illegal pairs.
        mode = 2;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] rx, ry;
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            rx = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            ry = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            send(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
